// File: rtl/refr_sched_pkg.sv
// Shared types and constants for the refresh scheduler.
package refr_sched_pkg;

    // The FSM reflects the refresh debt: none, some, or too much.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } refr_state_e;

    // Width of the optional stall statistics counter.
    localparam int STALL_W = 16;

endpackage

// File: rtl/refr_window_cnt.sv
// M-in-N window generator: pulses accrue on M cycles out of every N.
// N=0 disables the generator; accrue then stays low.
module refr_window_cnt #(
    parameter int M = 1,
    parameter int N = 0
) (
    input  logic clk,
    input  logic rst,
    output logic accrue
);

    localparam bit          EN     = (N != 0);
    localparam logic [31:0] RELOAD = EN ? 32'(N - 1) : 32'd0;

    logic [31:0] cnt;

    // Down-counter that wraps to N-1; one full pass is one window.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (cnt != 32'd0)
            cnt <= cnt - 32'd1;
        else
            cnt <= RELOAD;
    end

    assign accrue = EN && (cnt < 32'(M));

endmodule

// File: rtl/refr_scheduler.sv
// Refresh scheduler: shares one memory port between users and refresh.
// Refresh debt accrues from the window generator and is paid back in idle
// user cycles; at MAX_DEFER the block forces refresh and blocks users.
// Optional: define REFR_SCHEDULER_STATS_EN to build the FORCE stall counter.
module refr_scheduler
    import refr_sched_pkg::*;
#(
    parameter int REFRESH_M_IN_N_M = 1,
    parameter int REFRESH_M_IN_N_N = 0,
    parameter int MAX_DEFER        = 8,
    parameter int DEBT_W           = $clog2(MAX_DEFER + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               user_req,
    output logic               user_rdy,
    output logic               refr,
    output logic [DEBT_W-1:0]  refr_debt,
    output logic               refr_force,
    output logic [STALL_W-1:0] refr_stall_cnt
);

    localparam logic [DEBT_W:0] DMAX = (DEBT_W + 1)'(MAX_DEFER);

    refr_state_e       state, state_next;
    logic [DEBT_W-1:0] debt;
    logic [DEBT_W:0]   debt_sum, debt_next;
    logic              accrue;

    refr_window_cnt #(
        .M (REFRESH_M_IN_N_M),
        .N (REFRESH_M_IN_N_N)
    ) u_window (
        .clk    (clk),
        .rst    (rst),
        .accrue (accrue)
    );

    // Port arbitration: users win in PEND, refresh owns the port in FORCE.
    always_comb begin
        refr     = 1'b0;
        user_rdy = 1'b1;
        case (state)
            PEND:    refr = ~user_req;
            FORCE: begin
                refr     = 1'b1;
                user_rdy = 1'b0;
            end
            default: ;
        endcase
    end

    // Debt update; issue only happens with debt>0 so no underflow, and the
    // saturation keeps a PEND-state accrue from overshooting MAX_DEFER.
    always_comb begin
        debt_sum  = {1'b0, debt} + {{DEBT_W{1'b0}}, accrue} - {{DEBT_W{1'b0}}, refr};
        debt_next = (debt_sum > DMAX) ? DMAX : debt_sum;
    end

    // FORCE is sticky until the debt is fully paid off.
    always_comb begin
        if (debt_next == '0)
            state_next = IDLE;
        else if (state == FORCE || debt_next >= DMAX)
            state_next = FORCE;
        else
            state_next = PEND;
    end

    // Debt and state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            debt  <= '0;
            state <= IDLE;
        end else begin
            debt  <= debt_next[DEBT_W-1:0];
            state <= state_next;
        end
    end

    assign refr_debt  = debt;
    assign refr_force = (state == FORCE);

`ifdef REFR_SCHEDULER_STATS_EN
    logic [STALL_W-1:0] stall_cnt;

    // Count user cycles lost to forced refresh, saturating.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (state == FORCE && user_req && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign refr_stall_cnt = stall_cnt;
`else
    assign refr_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_refr_scheduler.sv
// Bench for refr_scheduler: three configurations side by side
// (0: M=2 N=10 D=4, 1: N=0, 2: M=N=4 D=4) checked against a debt model.
module tb_refr_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req    [3];
    logic        refr_o [3];
    logic        rdy_o  [3];
    logic        frc_o  [3];
    logic [15:0] stall_o[3];
    logic [2:0]  debt_a;
    logic [3:0]  debt_b;
    logic [2:0]  debt_c;

    refr_scheduler #(.REFRESH_M_IN_N_M(2), .REFRESH_M_IN_N_N(10), .MAX_DEFER(4)) u_a (
        .clk(clk), .rst(rst), .user_req(req[0]), .user_rdy(rdy_o[0]), .refr(refr_o[0]),
        .refr_debt(debt_a), .refr_force(frc_o[0]), .refr_stall_cnt(stall_o[0]));

    refr_scheduler #(.REFRESH_M_IN_N_M(1), .REFRESH_M_IN_N_N(0), .MAX_DEFER(8)) u_b (
        .clk(clk), .rst(rst), .user_req(req[1]), .user_rdy(rdy_o[1]), .refr(refr_o[1]),
        .refr_debt(debt_b), .refr_force(frc_o[1]), .refr_stall_cnt(stall_o[1]));

    refr_scheduler #(.REFRESH_M_IN_N_M(4), .REFRESH_M_IN_N_N(4), .MAX_DEFER(4)) u_c (
        .clk(clk), .rst(rst), .user_req(req[2]), .user_rdy(rdy_o[2]), .refr(refr_o[2]),
        .refr_debt(debt_c), .refr_force(frc_o[2]), .refr_stall_cnt(stall_o[2]));

    int PM[3] = '{2, 0, 4};
    int PN[3] = '{10, 0, 4};
    int PD[3] = '{4, 8, 4};

    // Reference model: debt as a plain integer, a "forced" flag, cycle index.
    int m_debt [3];
    int m_force[3];
    int m_stall[3];
    int kcyc;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        bit rst; bit req; bit refr; bit rdy; int debt; bit frc;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(string nm, int act, int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_debt[i]  = 0;
            m_force[i] = 0;
            m_stall[i] = 0;
        end
        kcyc = 0;
    endtask

    // Window position k: refresh is owed when k is a window start or within
    // the last M-1 cycles of the window (counter value below M).
    function automatic int owed(int i, int k);
        int pos;
        if (PN[i] == 0) return 0;
        pos = (PN[i] - (k % PN[i])) % PN[i];
        return (pos < PM[i]) ? 1 : 0;
    endfunction

    // Called just after a negedge with inputs set: compare, advance model.
    task automatic tick();
        int dd[3];
        int r, acc;
        #1;
        dd[0] = int'(debt_a);
        dd[1] = int'(debt_b);
        dd[2] = int'(debt_c);
        for (int i = 0; i < 3; i++) begin
            r = (m_force[i] != 0) ? 1 : ((m_debt[i] > 0 && !req[i]) ? 1 : 0);
            chk($sformatf("refr[%0d]", i),  int'(refr_o[i]), r);
            chk($sformatf("rdy[%0d]", i),   int'(rdy_o[i]), (m_force[i] != 0) ? 0 : 1);
            chk($sformatf("debt[%0d]", i),  dd[i], m_debt[i]);
            chk($sformatf("force[%0d]", i), int'(frc_o[i]), m_force[i]);
            chk($sformatf("stall[%0d]", i), int'(stall_o[i]), m_stall[i]);
            if (!rst) begin
                acc = owed(i, kcyc);
`ifdef REFR_SCHEDULER_STATS_EN
                if (m_force[i] != 0 && req[i] && m_stall[i] < 65535) m_stall[i]++;
`endif
                m_debt[i] = m_debt[i] + acc - r;
                if (m_debt[i] > PD[i]) m_debt[i] = PD[i];
                if (m_force[i] != 0) m_force[i] = (m_debt[i] != 0) ? 1 : 0;
                else                 m_force[i] = (m_debt[i] >= PD[i]) ? 1 : 0;
            end
        end
        if (rst) model_reset();
        else     kcyc++;
        @(negedge clk);
    endtask

    task automatic sync_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) req[i] = 1'b0;
        // Hand-derived cycle table for M=N=4, D=4.
        tbl[0]  = '{0, 0, 0, 1, 0, 0};
        tbl[1]  = '{0, 0, 1, 1, 1, 0};
        tbl[2]  = '{0, 0, 1, 1, 1, 0};
        tbl[3]  = '{0, 1, 0, 1, 1, 0};
        tbl[4]  = '{0, 1, 0, 1, 2, 0};
        tbl[5]  = '{0, 1, 0, 1, 3, 0};
        tbl[6]  = '{0, 1, 1, 0, 4, 1};
        tbl[7]  = '{0, 0, 1, 0, 4, 1};
        tbl[8]  = '{1, 0, 1, 0, 4, 1};
        tbl[9]  = '{0, 0, 0, 1, 0, 0};
        tbl[10] = '{0, 0, 1, 1, 1, 0};

        rst = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        rst = 1'b0;

        // Idle traffic for 100 cycles: periodic refresh, no forcing.
        for (int k = 0; k < 100; k++) tick();

        // Table for the M=N configuration, including a reset from FORCE.
        sync_reset();
        for (int v = 0; v < 11; v++) begin
            rst    = tbl[v].rst;
            req[2] = tbl[v].req;
            req[1] = 1'($urandom_range(0, 1));
            #1;
            chk($sformatf("tbl%0d.refr", v),  int'(refr_o[2]), int'(tbl[v].refr));
            chk($sformatf("tbl%0d.rdy", v),   int'(rdy_o[2]),  int'(tbl[v].rdy));
            chk($sformatf("tbl%0d.debt", v),  int'(debt_c),    tbl[v].debt);
            chk($sformatf("tbl%0d.force", v), int'(frc_o[2]),  int'(tbl[v].frc));
            tick();
        end
        rst    = 1'b0;
        req[2] = 1'b0;

        // Held user_req on M=2 N=10 D=4: FORCE window and accrue/issue overlap.
        sync_reset();
        req[0] = 1'b1;
        for (int k = 0; k < 30; k++) begin
            #1;
            if (k == 19) chk("held.rdy_before_force", int'(rdy_o[0]), 1);
            if (k == 20) begin
                chk("held.force_entry", int'(frc_o[0]), 1);
                chk("held.rdy_entry",   int'(rdy_o[0]), 0);
                chk("held.debt_entry",  int'(debt_a),   4);
            end
            if (k == 21) chk("held.debt_overlap", int'(debt_a), 4);
            if (k == 24) chk("held.still_force",  int'(frc_o[0]), 1);
            if (k == 25) begin
                chk("held.force_exit", int'(frc_o[0]), 0);
                chk("held.rdy_exit",   int'(rdy_o[0]), 1);
                chk("held.debt_exit",  int'(debt_a),   0);
`ifdef REFR_SCHEDULER_STATS_EN
                chk("held.stall", int'(stall_o[0]), 5);
`else
                chk("held.stall", int'(stall_o[0]), 0);
`endif
            end
            tick();
        end

        // Reset while in FORCE with debt=3.
        sync_reset();
        req[0] = 1'b1;
        for (int k = 0; k < 22; k++) tick();
        #1;
        chk("rstforce.debt_before",  int'(debt_a),   3);
        chk("rstforce.force_before", int'(frc_o[0]), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rstforce.debt",  int'(debt_a),    0);
        chk("rstforce.refr",  int'(refr_o[0]), 0);
        chk("rstforce.rdy",   int'(rdy_o[0]),  1);
        chk("rstforce.force", int'(frc_o[0]),  0);
        for (int k = 0; k < 40; k++) tick();

        // Random traffic with occasional resets.
        for (int k = 0; k < 1000; k++) begin
            for (int i = 0; i < 3; i++) req[i] = 1'($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
